output_post_data_module: RTL

OUTPUT_POST_DATA_MODULE -- requirements
Module: output_post_data_module

---
 rtl/output_post_data_module.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/output_post_data_module.sv
// Ping-pong result buffer that serializes a frame of signed words into bytes.
// Optional feature macro OUTPUT_SAT_EN: send one saturated signed byte per word.
module output_post_data_module #(
  parameter int DEPTH = 16,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [RES_W-1:0] i_res_din,
  input  logic             i_res_din_vld,
  input  logic             i_switch_pingpong,
  output logic [7:0]       o_data_dout,
  output logic             o_data_dout_vld,
  input  logic             i_dout_rdy,
  output logic             o_busy,
  output logic             o_wr_full,
  output logic             o_frame_done,
  output logic             o_switch_err,
  output logic [2:0]       o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SEND_HI = 3'd2,
    S_SEND_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Handshake: a byte transfers on a rising edge where o_data_dout_vld,
  // i_dout_rdy and en are all high; otherwise o_data_dout/o_data_dout_vld hold.
  // The result input has no back-pressure: words arriving while full are lost.

  state_t           state_q, state_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic             bank_q, bank_d;
  logic [RES_W-1:0] word_q, word_d;
  logic             err_q, err_d;

  logic [RES_W-1:0] mem_q [2*DEPTH];

  logic             wr_en;
  logic             sw_ok;
  logic [CW-1:0]    frame_len;
  logic [AW:0]      rd_addr;
  logic [7:0]       hi_byte;

  assign wr_en     = en && i_res_din_vld && (wcnt_q != FULL_CNT);
  assign sw_ok     = en && i_switch_pingpong && (state_q == S_IDLE);
  assign frame_len = wcnt_q + CW'(wr_en);
  assign rd_addr   = {~bank_q, raddr_q};

  // Bank storage is never reset; only the counters define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{bank_q, wcnt_q[AW-1:0]}] <= i_res_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      raddr_q <= '0;
      bank_q  <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      raddr_q <= raddr_d;
      bank_q  <= bank_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    raddr_d = raddr_q;
    bank_d  = bank_q;
    word_d  = word_q;
    err_d   = err_q;

    if (wr_en) wcnt_d = wcnt_q + CW'(1);
    if (en && i_switch_pingpong && (state_q != S_IDLE)) err_d = 1'b1;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          // The word written on the switch edge lands in the outgoing bank.
          if (sw_ok) begin
            bank_d  = ~bank_q;
            rcnt_d  = frame_len;
            wcnt_d  = '0;
            raddr_d = '0;
            state_d = (frame_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          word_d  = mem_q[rd_addr];
          raddr_d = raddr_q + AW'(1);
          rcnt_d  = rcnt_q - CW'(1);
          state_d = S_SEND_HI;
        end
        S_SEND_HI: begin
          if (i_dout_rdy) begin
`ifdef OUTPUT_SAT_EN
            state_d = (rcnt_q != '0) ? S_FETCH : S_DONE;
`else
            state_d = S_SEND_LO;
`endif
          end
        end
        S_SEND_LO: begin
          if (i_dout_rdy) state_d = (rcnt_q != '0) ? S_FETCH : S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_SAT_EN
  logic in_range;
  assign in_range = (word_q[RES_W-1:7] == {(RES_W-7){word_q[RES_W-1]}});
  assign hi_byte  = in_range ? word_q[7:0] : (word_q[RES_W-1] ? 8'h80 : 8'h7F);
`else
  assign hi_byte  = word_q[RES_W-1 -: 8];
`endif

  always_comb begin
    o_data_dout = 8'h00;
    if (state_q == S_SEND_HI)      o_data_dout = hi_byte;
    else if (state_q == S_SEND_LO) o_data_dout = word_q[7:0];
  end

  assign o_data_dout_vld = (state_q == S_SEND_HI) || (state_q == S_SEND_LO);
  assign o_busy          = (state_q != S_IDLE);
  assign o_frame_done    = (state_q == S_DONE);
  assign o_wr_full       = (wcnt_q == FULL_CNT);
  assign o_switch_err    = err_q;
  assign o_dbg_state     = state_q;

endmodule
